reorder_buffer: RTL and testbench
=================================

REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 Parameter ROB_DEPTH, default 16, number of entries (power of two); ROB id width = log2(ROB_DEPTH) = 4.
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 rst  in  1  reset, synchronous, active-low.
REQ-004 rdy  in  1  global enable; low -> state frozen, all single-cycle pulse outputs held low.
REQ-005 ID_issue_valid  in  1  decoder allocates one entry this cycle.
REQ-006 ID_has_rd / ID_rd  in  1 / 5  entry writes a register / destination index.
REQ-007 ID_is_branch / ID_pred_taken / ID_alt_pc  in  1 / 1 / 32  branch flag, prediction, PC to restart at if mispredicted.
REQ-008 ROB_full  out  1  no free entry; decoder must not issue.
REQ-009 ROB_rd_ROB_id  out  4  id the next issued entry receives (tail), sent to register file and stations.
REQ-010 CDB_valid / CDB_ROB_id / CDB_value / CDB_taken  in  1 / 4 / 32 / 1  execution result broadcast.
REQ-011 ROB_input_valid / ROB_rd / ROB_value  out  1 / 5 / 32  commit write to register file.
REQ-012 ROB_commit_ROB_id  out  4  id of committing entry.
REQ-013 QRY_id1 / QRY_id2  in  4 / 4  operand lookup by ROB id; QRY_ready1/2 out 1, QRY_value1/2 out 32.
REQ-014 ROB_roll_back_flag / ROB_roll_back_pc  out  1 / 32  misprediction flush pulse and restart PC.

Function
REQ-015 Circular buffer: head, tail pointers (4 bit, wrap modulo ROB_DEPTH) plus count (5 bit, 0..ROB_DEPTH).
REQ-016 ROB_full = (count == ROB_DEPTH), from registered count; issue when full is ignored, even if a commit occurs that cycle.
REQ-017 Issue: entry[tail] <= {busy=1, ready=0, fields}; tail <= tail+1; ROB_rd_ROB_id = tail (combinational from register).
REQ-018 Writeback: CDB_valid with busy entry sets ready=1, value, taken; CDB to non-busy entry ignored.
REQ-019 Commit: at most one per cycle, when count>0 and entry[head].ready; head <= head+1; busy cleared.
REQ-020 Earliest commit: cycle after CDB write (entry written at edge N commits at edge N+1); no same-cycle CDB-to-commit.
REQ-021 Non-branch commit: ROB_input_valid=1 for one cycle iff has_rd and rd != 0; ROB_rd, ROB_value, ROB_commit_ROB_id driven registered.
REQ-022 Branch commit with taken != pred_taken: ROB_roll_back_flag=1 one cycle, ROB_roll_back_pc = alt_pc; next state head=tail=0, count=0, all busy=0; issue in that cycle dropped.
REQ-023 Correct branch commit: no register write, no roll-back.
REQ-024 Simultaneous issue+commit: count unchanged; issue-only +1; commit-only -1.
REQ-025 Query: QRY_readyN = busy & ready of entry[QRY_idN]; QRY_valueN = its value; combinational.
REQ-026 rdy low: pointers, count, entries unchanged; ROB_input_valid and ROB_roll_back_flag 0.

Reset
REQ-027 rst low at posedge: head=tail=count=0, all busy/ready 0, ROB_full=0, ROB_input_valid=0, ROB_roll_back_flag=0, ROB_rd=0, ROB_value=0, ROB_commit_ROB_id=0, ROB_roll_back_pc=0.
REQ-028 Reset overrides issue, CDB and commit in the same cycle, including mid-operation with a full buffer.

Configuration
REQ-029 Macro ROB_QUERY_BYPASS_EN defined: QRY_readyN/valueN also true when CDB_valid and CDB_ROB_id == QRY_idN (CDB value forwarded same cycle); undefined: query reflects stored entry state only.

Verification
REQ-030 Reset, issue 16 entries with rd=1..16 (rd 16 is x16) -> ROB_full=1 after 16th; 17th issue ignored, tail wraps to 0.
REQ-031 Issue id0 rd=5, CDB id0 value 0x1234 at cycle N -> ROB_input_valid, ROB_rd=5, ROB_value=0x1234 at cycle N+1 pulse.
REQ-032 CDB writes id1 before id0 -> no commit until id0 ready; then id0, id1 commit on consecutive cycles.
REQ-033 Branch id0 pred_taken=0, alt_pc=0x100, CDB taken=1 -> ROB_roll_back_flag one cycle, pc=0x100, count=0, ROB_rd_ROB_id=0.
REQ-034 Full buffer, head ready, issue asserted -> commit occurs, issue dropped, count=15; rd=0 entry commits with ROB_input_valid=0.
REQ-035 QRY_id1=3 with CDB id3 same cycle -> QRY_ready1=1 only with ROB_QUERY_BYPASS_EN; rst low mid-run -> all REQ-027 values next cycle.

Source files
------------

// File: rtl/reorder_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | reorder_buffer : circular in-order commit buffer with CDB writeback,        |
// | operand query and branch-mispredict roll-back.                              |
// | Optional macro ROB_QUERY_BYPASS_EN forwards the CDB into the query ports.   |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module reorder_buffer #(
  parameter int ROB_DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rdy,
  input  logic                         ID_issue_valid,
  input  logic                         ID_has_rd,
  input  logic [4:0]                   ID_rd,
  input  logic                         ID_is_branch,
  input  logic                         ID_pred_taken,
  input  logic [31:0]                  ID_alt_pc,
  output logic                         ROB_full,
  output logic [$clog2(ROB_DEPTH)-1:0] ROB_rd_ROB_id,
  input  logic                         CDB_valid,
  input  logic [$clog2(ROB_DEPTH)-1:0] CDB_ROB_id,
  input  logic [31:0]                  CDB_value,
  input  logic                         CDB_taken,
  output logic                         ROB_input_valid,
  output logic [4:0]                   ROB_rd,
  output logic [31:0]                  ROB_value,
  output logic [$clog2(ROB_DEPTH)-1:0] ROB_commit_ROB_id,
  input  logic [$clog2(ROB_DEPTH)-1:0] QRY_id1,
  input  logic [$clog2(ROB_DEPTH)-1:0] QRY_id2,
  output logic                         QRY_ready1,
  output logic                         QRY_ready2,
  output logic [31:0]                  QRY_value1,
  output logic [31:0]                  QRY_value2,
  output logic                         ROB_roll_back_flag,
  output logic [31:0]                  ROB_roll_back_pc
);

  localparam int               c_IDW   = $clog2(ROB_DEPTH);
  localparam int               c_CW    = c_IDW + 1;
  localparam logic [c_CW-1:0]  c_DEPTH = c_CW'(ROB_DEPTH);

  logic [c_IDW-1:0]     r_head, r_tail;
  logic [c_CW-1:0]      r_count;
  logic [ROB_DEPTH-1:0] r_busy, r_ready, r_has_rd, r_is_branch, r_pred, r_taken;
  logic [4:0]           r_rd     [ROB_DEPTH];
  logic [31:0]          r_value  [ROB_DEPTH];
  logic [31:0]          r_alt_pc [ROB_DEPTH];

  logic                 r_input_valid, r_roll_back;
  logic [4:0]           r_out_rd;
  logic [31:0]          r_out_value, r_roll_back_pc;
  logic [c_IDW-1:0]     r_commit_id;

  logic w_full, w_commit, w_mispredict, w_issue, w_cdb;

  assign w_full       = (r_count == c_DEPTH);
  assign w_commit     = rdy && (r_count != '0) && r_ready[r_head];
  assign w_mispredict = w_commit && r_is_branch[r_head] &&
                        (r_taken[r_head] != r_pred[r_head]);
  // A full buffer refuses issue even when the head retires in the same cycle.
  assign w_issue      = rdy && ID_issue_valid && !w_full && !w_mispredict;
  assign w_cdb        = rdy && CDB_valid && r_busy[CDB_ROB_id];

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_head         <= '0;
      r_tail         <= '0;
      r_count        <= '0;
      r_busy         <= '0;
      r_ready        <= '0;
      r_input_valid  <= 1'b0;
      r_roll_back    <= 1'b0;
      r_out_rd       <= '0;
      r_out_value    <= '0;
      r_commit_id    <= '0;
      r_roll_back_pc <= '0;
    end else if (!rdy) begin
      r_input_valid  <= 1'b0;
      r_roll_back    <= 1'b0;
    end else begin
      r_input_valid <= w_commit && !r_is_branch[r_head] && r_has_rd[r_head] &&
                       (r_rd[r_head] != 5'd0);
      r_roll_back   <= w_mispredict;
      if (w_commit) begin
        r_out_rd    <= r_rd[r_head];
        r_out_value <= r_value[r_head];
        r_commit_id <= r_head;
      end
      if (w_mispredict) begin
        r_roll_back_pc <= r_alt_pc[r_head];
        r_head         <= '0;
        r_tail         <= '0;
        r_count        <= '0;
        r_busy         <= '0;
        r_ready        <= '0;
      end else begin
        if (w_cdb) begin
          r_ready[CDB_ROB_id] <= 1'b1;
          r_value[CDB_ROB_id] <= CDB_value;
          r_taken[CDB_ROB_id] <= CDB_taken;
        end
        // Retire clears after the CDB write so a late rewrite of the head cannot revive it.
        if (w_commit) begin
          r_busy[r_head]  <= 1'b0;
          r_ready[r_head] <= 1'b0;
          r_head          <= r_head + 1'b1;
        end
        if (w_issue) begin
          r_busy[r_tail]      <= 1'b1;
          r_ready[r_tail]     <= 1'b0;
          r_has_rd[r_tail]    <= ID_has_rd;
          r_rd[r_tail]        <= ID_rd;
          r_is_branch[r_tail] <= ID_is_branch;
          r_pred[r_tail]      <= ID_pred_taken;
          r_alt_pc[r_tail]    <= ID_alt_pc;
          r_tail              <= r_tail + 1'b1;
        end
        unique case ({w_issue, w_commit})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

  always_comb begin
    QRY_ready1 = r_busy[QRY_id1] & r_ready[QRY_id1];
    QRY_value1 = r_value[QRY_id1];
    QRY_ready2 = r_busy[QRY_id2] & r_ready[QRY_id2];
    QRY_value2 = r_value[QRY_id2];
`ifdef ROB_QUERY_BYPASS_EN
    if (CDB_valid && (CDB_ROB_id == QRY_id1)) begin
      QRY_ready1 = 1'b1;
      QRY_value1 = CDB_value;
    end
    if (CDB_valid && (CDB_ROB_id == QRY_id2)) begin
      QRY_ready2 = 1'b1;
      QRY_value2 = CDB_value;
    end
`else
`endif
  end

  assign ROB_full           = w_full;
  assign ROB_rd_ROB_id      = r_tail;
  assign ROB_input_valid    = r_input_valid;
  assign ROB_rd             = r_out_rd;
  assign ROB_value          = r_out_value;
  assign ROB_commit_ROB_id  = r_commit_id;
  assign ROB_roll_back_flag = r_roll_back;
  assign ROB_roll_back_pc   = r_roll_back_pc;

endmodule
`default_nettype wire

// File: tb/tb_reorder_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_reorder_buffer : directed and random checks of reorder_buffer against a |
// | queue-based reference model. Revision: 1.0                                 |
// +----------------------------------------------------------------------------+
module tb_reorder_buffer;
  localparam int D = 16;

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        ID_issue_valid, ID_has_rd, ID_is_branch, ID_pred_taken;
  logic [4:0]  ID_rd;
  logic [31:0] ID_alt_pc;
  logic        ROB_full;
  logic [3:0]  ROB_rd_ROB_id;
  logic        CDB_valid, CDB_taken;
  logic [3:0]  CDB_ROB_id;
  logic [31:0] CDB_value;
  logic        ROB_input_valid;
  logic [4:0]  ROB_rd;
  logic [31:0] ROB_value;
  logic [3:0]  ROB_commit_ROB_id;
  logic [3:0]  QRY_id1, QRY_id2;
  logic        QRY_ready1, QRY_ready2;
  logic [31:0] QRY_value1, QRY_value2;
  logic        ROB_roll_back_flag;
  logic [31:0] ROB_roll_back_pc;

  always #5 clk = ~clk;

  reorder_buffer #(.ROB_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .ID_issue_valid(ID_issue_valid), .ID_has_rd(ID_has_rd), .ID_rd(ID_rd),
    .ID_is_branch(ID_is_branch), .ID_pred_taken(ID_pred_taken), .ID_alt_pc(ID_alt_pc),
    .ROB_full(ROB_full), .ROB_rd_ROB_id(ROB_rd_ROB_id),
    .CDB_valid(CDB_valid), .CDB_ROB_id(CDB_ROB_id), .CDB_value(CDB_value), .CDB_taken(CDB_taken),
    .ROB_input_valid(ROB_input_valid), .ROB_rd(ROB_rd), .ROB_value(ROB_value),
    .ROB_commit_ROB_id(ROB_commit_ROB_id),
    .QRY_id1(QRY_id1), .QRY_id2(QRY_id2), .QRY_ready1(QRY_ready1), .QRY_ready2(QRY_ready2),
    .QRY_value1(QRY_value1), .QRY_value2(QRY_value2),
    .ROB_roll_back_flag(ROB_roll_back_flag), .ROB_roll_back_pc(ROB_roll_back_pc)
  );

  // Reference model: in-flight entries in program order, oldest at the front.
  typedef struct {
    int        id;
    bit        has_rd;
    bit [4:0]  rd;
    bit        br;
    bit        pred;
    bit [31:0] alt;
    bit        done;
    bit [31:0] val;
    bit        taken;
  } ent_t;

  ent_t      q[$];
  int        m_tail;
  bit        e_iv, e_rb;
  bit [4:0]  e_rd;
  bit [31:0] e_val, e_pc;
  int        e_cid;
  int        n_pass = 0, n_fail = 0, n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    ent_t c;
    bit   commit, flush, full;
    if (!rst) begin
      q.delete(); m_tail = 0;
      e_iv = 0; e_rb = 0; e_rd = 0; e_val = 0; e_pc = 0; e_cid = 0;
      return;
    end
    if (!rdy) begin
      e_iv = 0; e_rb = 0;
      return;
    end
    full   = (q.size() == D);
    commit = (q.size() > 0) && q[0].done;
    if (commit) c = q[0];
    flush = 0; e_iv = 0; e_rb = 0;
    if (CDB_valid)
      foreach (q[i]) if (q[i].id == int'(CDB_ROB_id)) begin
        q[i].done = 1; q[i].val = CDB_value; q[i].taken = CDB_taken;
      end
    if (commit) begin
      void'(q.pop_front());
      e_rd = c.rd; e_val = c.val; e_cid = c.id;
      if (c.br) begin
        if (c.taken != c.pred) begin
          e_rb = 1; e_pc = c.alt; flush = 1;
          q.delete(); m_tail = 0;
        end
      end else e_iv = c.has_rd && (c.rd != 0);
    end
    if (!flush && ID_issue_valid && !full) begin
      q.push_back('{m_tail, ID_has_rd, ID_rd, ID_is_branch, ID_pred_taken, ID_alt_pc, 1'b0, 32'd0, 1'b0});
      m_tail = (m_tail + 1) % D;
    end
  endtask

  task automatic qexp(input logic [3:0] id, output bit r, output bit [31:0] v);
    r = 0; v = 0;
    foreach (q[i]) if (q[i].id == int'(id) && q[i].done) begin r = 1; v = q[i].val; end
`ifdef ROB_QUERY_BYPASS_EN
    if (CDB_valid && CDB_ROB_id == id) begin r = 1; v = CDB_value; end
`endif
  endtask

  task automatic check_all();
    bit r; bit [31:0] v;
    chk("full", ROB_full, q.size() == D);
    chk("tail", ROB_rd_ROB_id, m_tail);
    chk("input_valid", ROB_input_valid, e_iv);
    chk("roll_back", ROB_roll_back_flag, e_rb);
    chk("commit_rd", ROB_rd, e_rd);
    chk("commit_value", ROB_value, e_val);
    chk("commit_id", ROB_commit_ROB_id, e_cid);
    chk("roll_back_pc", ROB_roll_back_pc, e_pc);
    qexp(QRY_id1, r, v);
    chk("qry1_ready", QRY_ready1, r);
    if (r) chk("qry1_value", QRY_value1, v);
    qexp(QRY_id2, r, v);
    chk("qry2_ready", QRY_ready2, r);
    if (r) chk("qry2_value", QRY_value2, v);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle();
    ID_issue_valid = 0; ID_has_rd = 0; ID_rd = 0; ID_is_branch = 0;
    ID_pred_taken = 0; ID_alt_pc = 0;
    CDB_valid = 0; CDB_ROB_id = 0; CDB_value = 0; CDB_taken = 0;
  endtask

  task automatic set_issue(input bit has_rd, input bit [4:0] rd, input bit br,
                           input bit pred, input bit [31:0] alt);
    ID_issue_valid = 1; ID_has_rd = has_rd; ID_rd = rd;
    ID_is_branch = br; ID_pred_taken = pred; ID_alt_pc = alt;
  endtask

  task automatic set_cdb(input bit [3:0] id, input bit [31:0] val, input bit taken);
    CDB_valid = 1; CDB_ROB_id = id; CDB_value = val; CDB_taken = taken;
  endtask

  task automatic do_reset();
    idle(); rst = 0; tick(); rst = 1;
  endtask

  initial begin
    rst = 0; rdy = 1; QRY_id1 = 0; QRY_id2 = 0;
    idle();
    tick();
    chk("rst_full", ROB_full, 0);
    chk("rst_tail", ROB_rd_ROB_id, 0);
    chk("rst_iv", ROB_input_valid, 0);
    rst = 1;

    // Fill all 16 entries; the 17th issue must be ignored.
    for (int i = 0; i < D; i++) begin
      idle(); set_issue(1, 5'(i + 1), 0, 0, 0); tick();
    end
    chk("full_after_16", ROB_full, 1);
    chk("tail_wrapped", ROB_rd_ROB_id, 0);
    idle(); set_issue(1, 5'd17, 0, 0, 0); tick();
    chk("issue_when_full_tail", ROB_rd_ROB_id, 0);
    chk("issue_when_full_full", ROB_full, 1);
    // Full buffer, head ready, issue asserted: commit happens, issue dropped.
    idle(); set_cdb(0, 32'hA5A5, 0); tick();
    idle(); set_issue(1, 5'd20, 0, 0, 0); tick();
    chk("full_commit_iv", ROB_input_valid, 1);
    chk("full_commit_rd", ROB_rd, 1);
    chk("full_commit_notfull", ROB_full, 0);
    chk("full_commit_tail", ROB_rd_ROB_id, 0);

    // rd=0 entry commits without a register write.
    do_reset();
    idle(); set_issue(1, 5'd7, 0, 0, 0); tick();
    idle(); set_issue(1, 5'd0, 0, 0, 0); tick();
    idle(); set_cdb(0, 32'h77, 0); tick();
    idle(); set_cdb(1, 32'h88, 0); tick();
    chk("rd7_iv", ROB_input_valid, 1);
    idle(); tick();
    chk("rd0_iv", ROB_input_valid, 0);
    chk("rd0_commit_id", ROB_commit_ROB_id, 1);

    // Writeback-to-commit latency.
    do_reset();
    idle(); set_issue(1, 5'd5, 0, 0, 0); tick();
    idle(); set_cdb(0, 32'h1234, 0); tick();
    chk("lat_no_same_cycle", ROB_input_valid, 0);
    idle(); tick();
    chk("lat_iv", ROB_input_valid, 1);
    chk("lat_rd", ROB_rd, 5);
    chk("lat_value", ROB_value, 32'h1234);
    idle(); tick();
    chk("lat_pulse_end", ROB_input_valid, 0);

    // Out-of-order writeback, in-order commit.
    do_reset();
    idle(); set_issue(1, 5'd3, 0, 0, 0); tick();
    idle(); set_issue(1, 5'd4, 0, 0, 0); tick();
    idle(); set_cdb(1, 32'h11, 0); tick();
    idle(); tick();
    chk("ooo_wait", ROB_input_valid, 0);
    idle(); set_cdb(0, 32'h22, 0); tick();
    idle(); tick();
    chk("ooo_first_rd", ROB_rd, 3);
    chk("ooo_first_val", ROB_value, 32'h22);
    idle(); tick();
    chk("ooo_second_iv", ROB_input_valid, 1);
    chk("ooo_second_id", ROB_commit_ROB_id, 1);
    chk("ooo_second_val", ROB_value, 32'h11);

    // Mispredicted branch flushes everything.
    do_reset();
    idle(); set_issue(0, 0, 1, 0, 32'h100); tick();
    idle(); set_issue(1, 5'd9, 0, 0, 0); tick();
    idle(); set_cdb(0, 0, 1); tick();
    idle(); set_issue(1, 5'd10, 0, 0, 0); tick();
    chk("mp_flag", ROB_roll_back_flag, 1);
    chk("mp_pc", ROB_roll_back_pc, 32'h100);
    chk("mp_tail", ROB_rd_ROB_id, 0);
    chk("mp_iv", ROB_input_valid, 0);
    idle(); tick();
    chk("mp_pulse_end", ROB_roll_back_flag, 0);

    // Query with same-cycle CDB on id3.
    do_reset();
    for (int i = 0; i < 4; i++) begin idle(); set_issue(1, 5'(i + 1), 0, 0, 0); tick(); end
    idle(); QRY_id1 = 3; set_cdb(3, 32'hBEEF, 0);
    #1;
`ifdef ROB_QUERY_BYPASS_EN
    chk("qry_bypass_ready", QRY_ready1, 1);
    chk("qry_bypass_value", QRY_value1, 32'hBEEF);
`else
    chk("qry_nobypass_ready", QRY_ready1, 0);
`endif
    tick();
    chk("qry_stored_ready", QRY_ready1, 1);
    chk("qry_stored_value", QRY_value1, 32'hBEEF);
    QRY_id1 = 0;

    // rdy low freezes state and holds pulses low.
    idle(); set_cdb(0, 32'h5, 0); tick();
    idle(); rdy = 0; set_issue(1, 5'd12, 0, 0, 0); tick();
    chk("rdy_low_iv", ROB_input_valid, 0);
    chk("rdy_low_tail", ROB_rd_ROB_id, 4);
    rdy = 1;

    // Reset mid-run with activity on every input.
    idle(); set_issue(1, 5'd13, 0, 0, 0); set_cdb(1, 32'h99, 0); rst = 0; tick(); rst = 1;
    chk("mid_rst_tail", ROB_rd_ROB_id, 0);
    chk("mid_rst_value", ROB_value, 0);
    chk("mid_rst_rd", ROB_rd, 0);
    chk("mid_rst_id", ROB_commit_ROB_id, 0);
    chk("mid_rst_pc", ROB_roll_back_pc, 0);
    idle(); tick();

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      idle();
      rst = ($urandom_range(0, 79) != 0);
      rdy = ($urandom_range(0, 99) < 85);
      if ($urandom_range(0, 99) < 60)
        set_issue($urandom_range(0, 99) < 80, 5'($urandom_range(0, 31)),
                  $urandom_range(0, 99) < 25, 1'($urandom_range(0, 1)), $urandom);
      if ($urandom_range(0, 1) == 1) begin
        if (q.size() > 0 && $urandom_range(0, 9) < 7)
          set_cdb(4'(q[$urandom_range(0, q.size() - 1)].id), $urandom, 1'($urandom_range(0, 1)));
        else
          set_cdb(4'($urandom_range(0, 15)), $urandom, 1'($urandom_range(0, 1)));
      end
      QRY_id1 = 4'($urandom_range(0, 15));
      QRY_id2 = 4'($urandom_range(0, 15));
      tick();
    end
    rst = 1; rdy = 1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire
